// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared widths, instruction payload type and opcode class helper
// for the issue-stage scoreboard.
package issue_scoreboard_pkg;
   localparam int LEN_OPECODE = 7;
   localparam int LEN_IMMF    = 1;
   localparam int LEN_REGNO   = 5;
   localparam int LEN_CC      = 4;
   localparam int LEN_IMM_EX  = 32;
   localparam int NUM_REG     = 1 << LEN_REGNO;
   localparam logic [2:0] CLS_NOWB = 3'b011;

   typedef logic [LEN_REGNO-1:0] regno_t;
   typedef logic [LEN_REGNO:0]   cnt_t;

   typedef struct packed {
      logic [LEN_OPECODE-1:0] opecode;
      logic [LEN_IMMF-1:0]    immf;
      regno_t                 rd;
      regno_t                 rs;
      logic [LEN_CC-1:0]      cc;
      logic [LEN_IMM_EX-1:0]  imm_ex;
   } issue_t;

   // Branch/store class never writes its rd field.
   function automatic logic writes_rd(input logic [LEN_OPECODE-1:0] op);
      return op[6:4] != CLS_NOWB;
   endfunction
endpackage

// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: decoder input stream, execute issue slot and writeback port
// bundled for the issue scoreboard.
interface issue_scoreboard_if;
   import issue_scoreboard_pkg::*;
   logic   dec_valid;
   logic   dec_stall;
   issue_t dec_ins;
   logic   ex_valid;
   logic   ex_stall;
   issue_t ex_ins;
   logic   wb_valid;
   regno_t wb_rd;
   cnt_t   busy_cnt;

   modport master (
      output dec_valid, dec_ins, ex_stall, wb_valid, wb_rd,
      input  dec_stall, ex_valid, ex_ins, busy_cnt
   );
   modport slave (
      input  dec_valid, dec_ins, ex_stall, wb_valid, wb_rd,
      output dec_stall, ex_valid, ex_ins, busy_cnt
   );
endinterface

// File: rtl/issue_scoreboard_busy.sv
// sb_regfile_busy: per-register busy bits with writeback bypass on lookups,
// set-over-clear priority and an incrementally maintained busy count.
module sb_regfile_busy
   import issue_scoreboard_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_set_en,
   input  regno_t i_set_idx,
   input  logic   i_clr_en,
   input  regno_t i_clr_idx,
   input  regno_t i_rd_idx,
   input  regno_t i_rs_idx,
   output logic   o_rd_q,
   output logic   o_rs_q,
   output cnt_t   o_cnt
);
   logic [NUM_REG-1:0] r_busy;
   logic [NUM_REG-1:0] w_clr_mask;
   logic [NUM_REG-1:0] w_set_mask;
   logic [NUM_REG-1:0] w_busy_eff;
   logic               w_set;
   logic               w_inc;
   logic               w_dec;
   cnt_t               r_cnt;

   assign w_clr_mask = i_clr_en ? NUM_REG'(1) << i_clr_idx : '0;
   assign w_busy_eff = r_busy & ~w_clr_mask;
   assign w_set      = i_set_en && i_set_idx != '0;
   assign w_set_mask = w_set ? NUM_REG'(1) << i_set_idx : '0;
   // A clear of a free register is a no-op, so the count cannot underflow.
   assign w_dec      = i_clr_en & r_busy[i_clr_idx];
   assign w_inc      = w_set & ~w_busy_eff[i_set_idx];
   assign o_rd_q     = w_busy_eff[i_rd_idx];
   assign o_rs_q     = w_busy_eff[i_rs_idx];
   assign o_cnt      = r_cnt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_eff | w_set_mask;
         r_cnt  <= r_cnt + cnt_t'(w_inc) - cnt_t'(w_dec);
      end
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: holds decoded instructions until their registers are free and
// presents them through a single registered issue slot with valid/stall handshake.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   issue_scoreboard_if.slave  bus
);
   logic   w_rd_q;
   logic   w_rs_q;
   logic   w_hazard;
   logic   w_slot_free;
   logic   w_issue;
   logic   r_valid;
   issue_t r_ins;

   sb_regfile_busy u_busy (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_set_en  (w_issue & writes_rd(bus.dec_ins.opecode)),
      .i_set_idx (bus.dec_ins.rd),
      .i_clr_en  (bus.wb_valid),
      .i_clr_idx (bus.wb_rd),
      .i_rd_idx  (bus.dec_ins.rd),
      .i_rs_idx  (bus.dec_ins.rs),
      .o_rd_q    (w_rd_q),
      .o_rs_q    (w_rs_q),
      .o_cnt     (bus.busy_cnt)
   );

   assign w_hazard      = w_rd_q | (~bus.dec_ins.immf[0] & w_rs_q);
   assign w_slot_free   = ~r_valid | ~bus.ex_stall;
   assign w_issue       = bus.dec_valid & ~w_hazard & w_slot_free;
   assign bus.dec_stall = bus.dec_valid & ~w_issue;
   assign bus.ex_valid  = r_valid;
   assign bus.ex_ins    = r_ins;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         r_valid <= 1'b0;
      else if (w_issue)
         r_valid <= 1'b1;
      else if (w_slot_free)
         r_valid <= 1'b0;

   // Payload needs no reset; it is only meaningful while r_valid is set.
   always_ff @(posedge clk)
      if (w_issue)
         r_ins <= bus.dec_ins;
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed vector table, hand-written stall/reset sequences and
// a randomized stream, all checked against a register-array reference model.
module tb_issue_scoreboard;
   import issue_scoreboard_pkg::*;

   localparam logic [6:0] ALU = 7'h10;
   localparam logic [6:0] BR  = 7'h30;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   issue_scoreboard_if bus ();
   issue_scoreboard dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int     n_chk = 0;
   int     n_fail = 0;
   bit     m_busy [NUM_REG];
   bit     m_valid = 1'b0;
   issue_t m_ins;
   logic   obs_stall = 1'b0;

   typedef struct {
      bit         v;
      logic [6:0] op;
      bit         immf;
      regno_t     rd;
      regno_t     rs;
      bit         wbv;
      regno_t     wbrd;
      bit         st;
      bit         e_stall;
      bit         e_valid;
      cnt_t       e_cnt;
   } vec_t;
   vec_t tbl [18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_cnt();
      int c = 0;
      foreach (m_busy[i]) c += int'(m_busy[i]);
      return c;
   endfunction

   function automatic bit blocked(input regno_t r, input bit wbv, input regno_t wbrd);
      return r != 0 && m_busy[r] && !(wbv && wbrd == r);
   endfunction

   function automatic issue_t mk(input logic [6:0] op, input bit immf, input regno_t rd,
                                 input regno_t rs, input int tag);
      issue_t t;
      t.opecode = op;
      t.immf    = immf;
      t.rd      = rd;
      t.rs      = rs;
      t.cc      = 4'(tag);
      t.imm_ex  = 32'hA5A5_0000 + 32'(tag);
      return t;
   endfunction

   // Drive one cycle, check combinational stall at negedge, registered outputs after the edge.
   task automatic apply(input bit v, input issue_t ins, input bit wbv, input regno_t wbrd, input bit st);
      bit hz, iss;
      bus.dec_valid = v;
      bus.dec_ins   = ins;
      bus.wb_valid  = wbv;
      bus.wb_rd     = wbrd;
      bus.ex_stall  = st;
      @(negedge clk);
      hz  = blocked(ins.rd, wbv, wbrd) || (ins.immf == 0 && blocked(ins.rs, wbv, wbrd));
      iss = v && !hz && (!m_valid || !st);
      obs_stall = bus.dec_stall;
      check("stall_o", 64'(bus.dec_stall), 64'(v && !iss));
      if (wbv) m_busy[wbrd] = 1'b0;
      if (iss && ins.opecode[6:4] != 3'b011 && ins.rd != 0) m_busy[ins.rd] = 1'b1;
      if (iss) begin
         m_valid = 1'b1;
         m_ins   = ins;
      end else if (!m_valid || !st) m_valid = 1'b0;
      @(posedge clk);
      #1;
      check("valid_o", 64'(bus.ex_valid), 64'(m_valid));
      check("busy_cnt_o", 64'(bus.busy_cnt), 64'(m_cnt()));
      if (m_valid) check("payload", 64'(bus.ex_ins), 64'(m_ins));
   endtask

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_valid   = 1'b0;
      obs_stall = 1'b0;
   endtask

   initial begin
      issue_t a, b, ins;
      bit v;
      bus.dec_valid = 1'b0;
      bus.dec_ins   = '0;
      bus.ex_stall  = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.wb_rd     = '0;
      model_reset();
      tbl = '{
         '{1'b1, ALU, 1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd1},
         '{1'b1, ALU, 1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd2},
         '{1'b1, ALU, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd3},
         '{1'b1, ALU, 1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd4},
         '{1'b1, ALU, 1'b0, 5'd5, 5'd4, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd4},
         '{1'b1, ALU, 1'b0, 5'd5, 5'd4, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd4},
         '{1'b1, ALU, 1'b0, 5'd5, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 6'd4},
         '{1'b1, ALU, 1'b1, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd5},
         '{1'b1, ALU, 1'b1, 5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 6'd5},
         '{1'b0, ALU, 1'b1, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 6'd4},
         '{1'b1, BR,  1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd4},
         '{1'b1, ALU, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd4},
         '{1'b0, ALU, 1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 6'd4},
         '{1'b0, ALU, 1'b1, 5'd0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 6'd3},
         '{1'b0, ALU, 1'b1, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 6'd2},
         '{1'b0, ALU, 1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 6'd1},
         '{1'b0, ALU, 1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 6'd0},
         '{1'b0, ALU, 1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 6'd0}
      };
      #12;
      check("reset valid_o", 64'(bus.ex_valid), 64'd0);
      check("reset busy_cnt_o", 64'(bus.busy_cnt), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         apply(tbl[i].v, mk(tbl[i].op, tbl[i].immf, tbl[i].rd, tbl[i].rs, i),
               tbl[i].wbv, tbl[i].wbrd, tbl[i].st);
         check($sformatf("tbl%0d stall_o", i), 64'(obs_stall), 64'(tbl[i].e_stall));
         check($sformatf("tbl%0d valid_o", i), 64'(bus.ex_valid), 64'(tbl[i].e_valid));
         check($sformatf("tbl%0d busy_cnt_o", i), 64'(bus.busy_cnt), 64'(tbl[i].e_cnt));
      end

      // Downstream stall holds A while B waits, then B follows exactly once.
      a = mk(ALU, 1'b1, 5'd10, 5'd0, 100);
      b = mk(ALU, 1'b1, 5'd11, 5'd0, 101);
      apply(1'b1, a, 1'b0, 5'd0, 1'b0);
      check("hold A loaded", 64'(bus.ex_ins), 64'(a));
      repeat (3) begin
         apply(1'b1, b, 1'b0, 5'd0, 1'b1);
         check("hold stall_o", 64'(obs_stall), 64'd1);
         check("hold valid_o", 64'(bus.ex_valid), 64'd1);
         check("hold frozen", 64'(bus.ex_ins), 64'(a));
      end
      apply(1'b1, b, 1'b0, 5'd0, 1'b0);
      check("release stall_o", 64'(obs_stall), 64'd0);
      check("release B loaded", 64'(bus.ex_ins), 64'(b));
      apply(1'b0, b, 1'b0, 5'd0, 1'b0);
      check("release bubble", 64'(bus.ex_valid), 64'd0);
      check("release busy_cnt_o", 64'(bus.busy_cnt), 64'd2);

      // Asynchronous reset while the slot is full and registers are busy.
      apply(1'b1, mk(ALU, 1'b1, 5'd12, 5'd0, 102), 1'b0, 5'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async valid_o", 64'(bus.ex_valid), 64'd0);
      check("async busy_cnt_o", 64'(bus.busy_cnt), 64'd0);
      model_reset();
      bus.dec_valid = 1'b0;
      bus.wb_valid  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply(1'b0, '0, 1'b1, 5'd10, 1'b0);
      check("post-reset valid_o", 64'(bus.ex_valid), 64'd0);
      check("post-reset busy_cnt_o", 64'(bus.busy_cnt), 64'd0);

      v   = 1'b0;
      ins = '0;
      for (int i = 0; i < 500; i++) begin
         if (!obs_stall) begin
            v   = $urandom_range(0, 3) != 0;
            ins = mk(($urandom_range(0, 3) == 0) ? BR : ALU, 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), i + 200);
         end
         apply(v, ins, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
